// File: rtl/c2c_pkg.sv
// Shared c2c_w bus widths, the posted-write entry type and the word-address helper.
package c2c_pkg;
    localparam int unsigned C2C_XLEN   = 32;
    localparam int unsigned C2C_SEL_W  = C2C_XLEN / 8;
    localparam int unsigned C2C_OFF_W  = $clog2(C2C_SEL_W);
    localparam int unsigned C2C_WORD_W = C2C_XLEN - C2C_OFF_W;

    typedef struct packed {
        logic [C2C_WORD_W-1:0] word;
        logic [C2C_SEL_W-1:0]  sel;
        logic [C2C_XLEN-1:0]   data;
    } wbuf_entry_t;

    function automatic logic [C2C_WORD_W-1:0] word_addr(input logic [C2C_XLEN-1:0] addr);
        return addr[C2C_XLEN-1:C2C_OFF_W];
    endfunction
endpackage

// File: rtl/c2c_write_buffer.sv
// Posted write buffer: acks core stores early, drains to memory in order, merges
// same-word stores into the newest entry and flags read-after-write hazards.
module c2c_write_buffer
    import c2c_pkg::*;
#(
    parameter int unsigned XLEN  = C2C_XLEN,
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [XLEN/8-1:0] sel,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   data,
    output logic              ack,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_sel,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_data,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   rd_addr,
    output logic              rd_hazard,
    output logic              empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    wbuf_entry_t           entries_q [DEPTH];
    wbuf_entry_t           head_e;
    wbuf_entry_t           merged;
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [PTR_W-1:0]      newest;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  ack_q;
    logic                  pop;
    logic                  merge;
    logic                  accept;
    logic                  alloc;
    logic [C2C_WORD_W-1:0] in_word;
    logic [C2C_WORD_W-1:0] rd_word;

    // Slot is live when its distance from head (mod DEPTH) is below the occupancy.
    function automatic logic slot_valid(input logic [PTR_W-1:0] idx,
                                        input logic [PTR_W-1:0] hd,
                                        input logic [CNT_W-1:0] cnt);
        logic [PTR_W-1:0] off;
        off = idx - hd;
        return {1'b0, off} < cnt;
    endfunction

    assign head_e   = entries_q[head_q];
    assign empty    = (count_q == '0);
    assign mem_we   = !empty;
    assign mem_sel  = head_e.sel;
    assign mem_addr = {head_e.word, {C2C_OFF_W{1'b0}}};
    assign mem_data = head_e.data;
    assign ack      = ack_q;

    assign in_word = word_addr(addr);
    assign rd_word = word_addr(rd_addr);
    assign newest  = tail_q - PTR_W'(1);
    assign pop     = mem_we && mem_ack;

    // With two or more entries the newest one can never be the head being presented.
    assign merge   = (count_q >= CNT_W'(2)) && (sel != '0) && (entries_q[newest].word == in_word);
    assign accept  = we && !ack_q && (merge || (count_q < FULL));
    assign alloc   = accept && !merge && (sel != '0);
    assign count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);

    always_comb begin
        merged     = entries_q[newest];
        merged.sel = merged.sel | sel;
        for (int b = 0; b < C2C_SEL_W; b++) begin
            if (sel[b]) merged.data[8*b +: 8] = data[8*b +: 8];
        end
    end

    always_comb begin
        rd_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid(PTR_W'(i), head_q, count_q) && (entries_q[i].word == rd_word)) begin
                rd_hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            ack_q   <= accept;
            count_q <= count_d;
            if (pop) head_q <= head_q + PTR_W'(1);
            if (alloc) begin
                entries_q[tail_q].word <= in_word;
                entries_q[tail_q].sel  <= sel;
                entries_q[tail_q].data <= data;
                tail_q                 <= tail_q + PTR_W'(1);
            end else if (accept && merge) begin
                entries_q[newest] <= merged;
            end
        end
    end
endmodule

// File: tb/tb_c2c_write_buffer.sv
// Bench for c2c_write_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized store/drain traffic.
module tb_c2c_write_buffer;
    import c2c_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] addr = '0;
    logic [31:0] data = '0;
    logic        ack;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ack = 1'b0;
    logic [31:0] rd_addr = '0;
    logic        rd_hazard;
    logic        empty;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    wbuf_entry_t mq[$];
    logic        m_ack = 1'b0;

    c2c_write_buffer #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .we(we), .sel(sel), .addr(addr), .data(data), .ack(ack),
        .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ack(mem_ack), .rd_addr(rd_addr), .rd_hazard(rd_hazard), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a FIFO of pending words, updated from the inputs seen at each edge.
    task automatic model_step();
        wbuf_entry_t e;
        int          n;
        logic        mrg;
        logic        acc;
        if (rst) begin
            mq.delete();
            m_ack = 1'b0;
            return;
        end
        n   = mq.size();
        mrg = 1'b0;
        if (we && sel != 4'h0 && n >= 2) mrg = (mq[n-1].word == addr[31:2]);
        acc = we && !m_ack && (mrg || n < DEPTH);
        if (acc && mrg) begin
            e = mq[n-1];
            e.sel = e.sel | sel;
            for (int b = 0; b < 4; b++) if (sel[b]) e.data[8*b +: 8] = data[8*b +: 8];
            mq[n-1] = e;
        end
        if (n > 0 && mem_ack) void'(mq.pop_front());
        if (acc && !mrg && sel != 4'h0) begin
            e.word = addr[31:2];
            e.sel  = sel;
            e.data = data;
            mq.push_back(e);
        end
        m_ack = acc;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial begin : compare
        int   n;
        logic hz;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                n = mq.size();
                check("ack", ack, m_ack);
                check("empty", empty, n == 0);
                check("mem_we", mem_we, n != 0);
                if (n > 0) begin
                    check("mem_addr", mem_addr, {mq[0].word, 2'b00});
                    check("mem_sel", mem_sel, mq[0].sel);
                    check("mem_data", mem_data, mq[0].data);
                end
                hz = 1'b0;
                foreach (mq[i]) if (mq[i].word == rd_addr[31:2]) hz = 1'b1;
                check("rd_hazard", rd_hazard, hz);
            end
        end
    end

    task automatic store(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                         output int lat);
        we = 1'b1; sel = s; addr = a; data = d; lat = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            lat++;
            if (ack) break;
        end
        check("store_ack", ack, 1'b1);
        we = 1'b0;
    endtask

    task automatic drain();
        mem_ack = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (empty) break;
            step();
        end
        mem_ack = 1'b0;
        check("drain_empty", empty, 1'b1);
    endtask

    initial begin
        int lat;
        step();
        chk_en = 1'b1;
        step();
        check("rst_ack", ack, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_hazard", rd_hazard, 1'b0);
        rst = 1'b0;
        step();

        // Single store round trip.
        store(4'hF, 32'h100, 32'hDEADBEEF, lat);
        check("t1_latency", lat, 1);
        check("t1_mem_we", mem_we, 1'b1);
        check("t1_mem_addr", mem_addr, 32'h100);
        check("t1_mem_sel", mem_sel, 4'hF);
        check("t1_mem_data", mem_data, 32'hDEADBEEF);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("t1_empty", empty, 1'b1);

        // Fill to DEPTH, fifth store waits for a pop.
        store(4'hF, 32'h0, 32'hA0, lat);
        store(4'hF, 32'h4, 32'hA1, lat);
        store(4'hF, 32'h8, 32'hA2, lat);
        store(4'hF, 32'hC, 32'hA3, lat);
        we = 1'b1; sel = 4'hF; addr = 32'h10; data = 32'hA4;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_full_no_ack", ack, 1'b0);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("t2_pop_cycle_no_ack", ack, 1'b0);
        step();
        check("t2_ack_after_pop", ack, 1'b1);
        we = 1'b0;
        drain();

        // Merge behind a busy head.
        store(4'hF, 32'h500, 32'h55555555, lat);
        store(4'h3, 32'h200, 32'h00001111, lat);
        store(4'hC, 32'h202, 32'h22220000, lat);
        mem_ack = 1'b1;
        step();
        check("t3_mem_addr", mem_addr, 32'h200);
        check("t3_mem_sel", mem_sel, 4'hF);
        check("t3_mem_data", mem_data, 32'h22221111);
        step();
        mem_ack = 1'b0;
        check("t3_single_entry", empty, 1'b1);

        // Hazard detection.
        store(4'hF, 32'h300, 32'h12345678, lat);
        rd_addr = 32'h302;
        #1 check("t4_hazard_same_word", rd_hazard, 1'b1);
        rd_addr = 32'h304;
        #1 check("t4_hazard_other_word", rd_hazard, 1'b0);
        rd_addr = 32'h302;
        drain();
        #1 check("t4_hazard_after_drain", rd_hazard, 1'b0);

        // Reset mid-drain.
        store(4'hF, 32'h400, 32'h1, lat);
        store(4'hF, 32'h404, 32'h2, lat);
        store(4'hF, 32'h408, 32'h3, lat);
        check("t5_mem_we_before", mem_we, 1'b1);
        rst = 1'b1;
        step();
        check("t5_mem_we", mem_we, 1'b0);
        check("t5_empty", empty, 1'b1);
        check("t5_ack", ack, 1'b0);
        rst = 1'b0;
        step();

        // Random traffic over a small address window so merges and hazards occur.
        for (int c = 0; c < 3000; c++) begin
            if (we && ack) we = 1'b0;
            if (!we && $urandom_range(0, 2) != 0) begin
                we   = 1'b1;
                sel  = 4'($urandom_range(0, 15));
                addr = 32'h600 + 32'($urandom_range(0, 31));
                data = $urandom;
            end
            mem_ack = ($urandom_range(0, 4) < 2);
            rd_addr = 32'h600 + 32'($urandom_range(0, 31));
            step();
        end
        mem_ack = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (we && ack) we = 1'b0;
            if (!we && empty) break;
            step();
        end
        mem_ack = 1'b0;
        check("final_drain_empty", empty, 1'b1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
